// File: rtl/memory_stage.sv
// memory_stage: pipeline MEM stage between execute and writeback.
// Turns load/store instructions into data-bus requests (byte strobes,
// lane-shifted store data) and extracts/extends returned load data.
// Non-memory instructions pass straight through with the ALU result.

package memory_stage_pkg;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic [1:0] msize;
        logic       msext;
    } mem_ctl_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  dst;
        mem_ctl_t    ctl;
        logic [63:0] aluout;
        logic [63:0] srcb;
    } execute_data_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  dst;
        mem_ctl_t    ctl;
        logic [63:0] result;
        logic        misalign;
    } memory_data_t;

endpackage

module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  execute_data_t   dataE,
    output logic            stallM,
    output memory_data_t    dataM,
    output logic            dreq_valid,
    output logic [AW-1:0]   dreq_addr,
    output logic [2:0]      dreq_size,
    output logic [DW/8-1:0] dreq_strobe,
    output logic [DW-1:0]   dreq_data,
    input  logic            dresp_data_ok,
    input  logic [DW-1:0]   dresp_data
);

    localparam int SW = DW / 8;
    localparam int LB = $clog2(SW);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [2:0]      size_q, size_d;
    logic [SW-1:0]   strobe_q, strobe_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [4:0]      dst_q, dst_d;
    mem_ctl_t        ctl_q, ctl_d;
    logic [63:0]     rbuf_q, rbuf_d;

    logic            mem_op;
    logic            misaligned;
    logic [AW-1:0]   e_addr;
    logic [SW-1:0]   e_strobe;
    logic [DW-1:0]   e_wdata;

    // Shift the addressed lane down to bit 0, keep the access width and extend.
    function automatic logic [63:0] load_extend(input logic [DW-1:0] rdata,
                                                input logic [LB-1:0] lane,
                                                input logic [1:0]    size,
                                                input logic          sext);
        logic [DW-1:0] sh;
        sh = rdata >> {lane, 3'b000};
        case (size)
            2'd0:    load_extend = {{56{sext & sh[7]}},  sh[7:0]};
            2'd1:    load_extend = {{48{sext & sh[15]}}, sh[15:0]};
            2'd2:    load_extend = {{32{sext & sh[31]}}, sh[31:0]};
            default: load_extend = sh[63:0];
        endcase
    endfunction

    // Decode the incoming instruction: memory-op flag, alignment, strobes and store data.
    always_comb begin
        mem_op   = dataE.valid & (dataE.ctl.memread | dataE.ctl.memwrite);
        e_addr   = dataE.aluout[AW-1:0];
        case (dataE.ctl.msize)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = e_addr[0];
            2'd2:    misaligned = |e_addr[1:0];
            default: misaligned = |e_addr[2:0];
        endcase
        case (dataE.ctl.msize)
            2'd0:    e_strobe = SW'(8'h01);
            2'd1:    e_strobe = SW'(8'h03);
            2'd2:    e_strobe = SW'(8'h0F);
            default: e_strobe = SW'(8'hFF);
        endcase
        e_strobe = dataE.ctl.memwrite ? (e_strobe << e_addr[LB-1:0]) : '0;
        e_wdata  = dataE.srcb[DW-1:0] << {e_addr[LB-1:0], 3'b000};
    end

    // State and latched-request registers; synchronous reset abandons any request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            strobe_q <= '0;
            wdata_q  <= '0;
            dst_q    <= '0;
            ctl_q    <= '0;
            rbuf_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            strobe_q <= strobe_d;
            wdata_q  <= wdata_d;
            dst_q    <= dst_d;
            ctl_q    <= ctl_d;
            rbuf_q   <= rbuf_d;
        end
    end

    // Next-state logic: latch the request on issue, capture load data on completion.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        strobe_d = strobe_q;
        wdata_d  = wdata_q;
        dst_d    = dst_q;
        ctl_d    = ctl_q;
        rbuf_d   = rbuf_q;
        case (state_q)
            S_IDLE: begin
                if (mem_op && !misaligned) begin
                    state_d  = dresp_data_ok ? S_DONE : S_WAIT;
                    addr_d   = e_addr;
                    size_d   = {1'b0, dataE.ctl.msize};
                    strobe_d = e_strobe;
                    wdata_d  = e_wdata;
                    dst_d    = dataE.dst;
                    ctl_d    = dataE.ctl;
                    if (dresp_data_ok) begin
                        rbuf_d = load_extend(dresp_data, e_addr[LB-1:0],
                                             dataE.ctl.msize, dataE.ctl.msext);
                    end
                end
            end
            S_WAIT: begin
                if (dresp_data_ok) begin
                    state_d = S_DONE;
                    rbuf_d  = load_extend(dresp_data, addr_q[LB-1:0],
                                          ctl_q.msize, ctl_q.msext);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: bus request, stall and the record handed to writeback.
    always_comb begin
        stallM      = 1'b0;
        dataM       = '0;
        dreq_valid  = 1'b0;
        dreq_addr   = '0;
        dreq_size   = '0;
        dreq_strobe = '0;
        dreq_data   = '0;
        case (state_q)
            S_IDLE: begin
                if (dataE.valid) begin
                    if (!mem_op || misaligned) begin
                        dataM.valid    = 1'b1;
                        dataM.dst      = dataE.dst;
                        dataM.ctl      = dataE.ctl;
                        dataM.result   = dataE.aluout;
                        dataM.misalign = mem_op;
                    end else begin
                        stallM      = 1'b1;
                        dreq_valid  = 1'b1;
                        dreq_addr   = e_addr;
                        dreq_size   = {1'b0, dataE.ctl.msize};
                        dreq_strobe = e_strobe;
                        dreq_data   = e_wdata;
                    end
                end
            end
            S_WAIT: begin
                stallM      = 1'b1;
                dreq_valid  = 1'b1;
                dreq_addr   = addr_q;
                dreq_size   = size_q;
                dreq_strobe = strobe_q;
                dreq_data   = wdata_q;
            end
            S_DONE: begin
                dataM.valid  = 1'b1;
                dataM.dst    = dst_q;
                dataM.ctl    = ctl_q;
                dataM.result = ctl_q.memread ? rbuf_q : 64'(addr_q);
            end
            default: ;
        endcase
    end

endmodule
